oscillator_sequencer: RTL

OSCILLATOR_SEQUENCER -- requirements
Module: oscillator_sequencer

---
 rtl/sine_pkg.sv | 11 +
 rtl/voice_ram.sv | 37 +++
 rtl/oscillator_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// sine_pkg: shared sine-lookup geometry and sequencer FSM states.
package sine_pkg;
   localparam int SINE_ARG_WIDTH    = 13;
   localparam int SINE_RESULT_WIDTH = 18;
   localparam int SINE_LATENCY      = 3;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;
endpackage

// File: rtl/voice_ram.sv
// voice_ram: per-voice phase/frequency storage; the read port advances the phase it reads.
module voice_ram
   import sine_pkg::*;
#(
   parameter int NUM_VOICES  = 8,
   parameter int PHASE_WIDTH = 24
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          rd_en_i,
   input  logic [$clog2(NUM_VOICES)-1:0] rd_idx_i,
   output logic [SINE_ARG_WIDTH-1:0]     rd_arg_o,
   input  logic                          wr_en_i,
   input  logic [$clog2(NUM_VOICES)-1:0] wr_idx_i,
   input  logic [PHASE_WIDTH-1:0]        wr_freq_i,
   input  logic                          wr_phase_rst_i
);
   localparam int VW = $clog2(NUM_VOICES);
   logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
   logic [PHASE_WIDTH-1:0] freq_q  [NUM_VOICES];
   assign rd_arg_o = phase_q[rd_idx_i][PHASE_WIDTH-1 -: SINE_ARG_WIDTH];
   // Reads see pre-edge contents; a phase reset wins over the accumulate.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            phase_q[v] <= '0;
            freq_q[v]  <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (wr_en_i && wr_idx_i == VW'(v)) freq_q[v] <= wr_freq_i;
            if (wr_en_i && wr_phase_rst_i && wr_idx_i == VW'(v)) phase_q[v] <= '0;
            else if (rd_en_i && rd_idx_i == VW'(v)) phase_q[v] <= phase_q[v] + freq_q[v];
         end
      end
   end
endmodule

// File: rtl/oscillator_sequencer.sv
// oscillator_sequencer: sweeps time-multiplexed phase accumulators through a shared
// pipelined sine lookup, tagging each argument so results come back labelled.
module oscillator_sequencer
   import sine_pkg::*;
#(
   parameter int NUM_VOICES  = 8,
   parameter int PHASE_WIDTH = 24
) (
   input  logic                                i_Clock,
   input  logic                                i_Reset_n,
   input  logic                                i_SampleStrobe,
   input  logic                                i_VoiceWrite,
   input  logic [$clog2(NUM_VOICES)-1:0]       i_VoiceIndex,
   input  logic [PHASE_WIDTH-1:0]              i_FrequencyWord,
   input  logic                                i_PhaseReset,
   output logic [SINE_ARG_WIDTH-1:0]           o_Argument,
   input  logic signed [SINE_RESULT_WIDTH-1:0] i_SineResult,
   output logic signed [SINE_RESULT_WIDTH-1:0] o_Sample,
   output logic [$clog2(NUM_VOICES)-1:0]       o_SampleVoice,
   output logic                                o_SampleValid,
   output logic                                o_Busy,
   output logic                                o_Overrun
);
   localparam int VW = $clog2(NUM_VOICES);
   typedef struct packed {
      logic          v;
      logic [VW-1:0] idx;
   } tag_t;
   state_e                              state_q, state_d;
   logic [VW-1:0]                       voice_q, svoice_q;
   tag_t                                tag_q [SINE_LATENCY+1];
   logic [SINE_ARG_WIDTH-1:0]           rd_arg, arg_q;
   logic signed [SINE_RESULT_WIDTH-1:0] sample_q;
   logic                                valid_q, busy_q, overrun_q;
   logic                                issue, last_issue, last_tag;
   always_comb begin
      issue      = state_q == ST_ISSUE;
      last_issue = issue && voice_q == VW'(NUM_VOICES-1);
      last_tag   = tag_q[SINE_LATENCY].v && tag_q[SINE_LATENCY].idx == VW'(NUM_VOICES-1);
      state_d    = state_q == ST_IDLE  ? (i_SampleStrobe ? ST_ISSUE : ST_IDLE) :
                   state_q == ST_ISSUE ? (last_issue ? ST_DRAIN : ST_ISSUE) :
                                         (last_tag ? ST_IDLE : ST_DRAIN);
   end
   voice_ram #(
      .NUM_VOICES (NUM_VOICES),
      .PHASE_WIDTH(PHASE_WIDTH)
   ) u_voice_ram (
      .clk_i         (i_Clock),
      .rst_ni        (i_Reset_n),
      .rd_en_i       (issue),
      .rd_idx_i      (voice_q),
      .rd_arg_o      (rd_arg),
      .wr_en_i       (i_VoiceWrite),
      .wr_idx_i      (i_VoiceIndex),
      .wr_freq_i     (i_FrequencyWord),
      .wr_phase_rst_i(i_PhaseReset)
   );
   // Tag stage k lines up with the lookup result k cycles after the argument register.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q   <= ST_IDLE;
         voice_q   <= '0;
         arg_q     <= '0;
         sample_q  <= '0;
         svoice_q  <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int k = 0; k <= SINE_LATENCY; k++) tag_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         voice_q   <= issue ? voice_q + 1'b1 : '0;
         busy_q    <= state_d != ST_IDLE;
         overrun_q <= i_SampleStrobe && state_q != ST_IDLE;
         if (issue) arg_q <= rd_arg;
         tag_q[0] <= '{v: issue, idx: voice_q};
         for (int k = 1; k <= SINE_LATENCY; k++) tag_q[k] <= tag_q[k-1];
         valid_q <= tag_q[SINE_LATENCY].v;
         if (tag_q[SINE_LATENCY].v) begin
            sample_q <= i_SineResult;
            svoice_q <= tag_q[SINE_LATENCY].idx;
         end
      end
   end
   assign o_Argument    = arg_q;
   assign o_Sample      = sample_q;
   assign o_SampleVoice = svoice_q;
   assign o_SampleValid = valid_q;
   assign o_Busy        = busy_q;
   assign o_Overrun     = overrun_q;
endmodule
